// File: rtl/normalized_motion_computer.sv
// Centroid-difference motion stage: per-window sum/count in fixed point,
// one shared restoring divider, low-activity gating and dominant-axis flag.
module normalized_motion_computer #(
    parameter  int SUM_BITS   = 18,
    parameter  int COUNT_BITS = 12,
    parameter  int FRAC_BITS  = 4,
    parameter  int MIN_COUNT  = 8,
    localparam int Q          = SUM_BITS + FRAC_BITS,
    localparam int D_BITS     = Q + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [SUM_BITS-1:0]   early_sum_x,
    input  logic signed [SUM_BITS-1:0]   early_sum_y,
    input  logic        [COUNT_BITS-1:0] early_count,
    input  logic signed [SUM_BITS-1:0]   late_sum_x,
    input  logic signed [SUM_BITS-1:0]   late_sum_y,
    input  logic        [COUNT_BITS-1:0] late_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [D_BITS-1:0]     delta_x,
    output logic signed [D_BITS-1:0]     delta_y,
    output logic        [D_BITS-1:0]     abs_delta_x,
    output logic        [D_BITS-1:0]     abs_delta_y,
    output logic        [COUNT_BITS:0]   total_events,
    output logic                         low_activity,
    output logic                         dominant_x
);

    localparam int CW = $clog2(Q);
    localparam logic [COUNT_BITS-1:0] MIN_C = COUNT_BITS'(MIN_COUNT);
    localparam logic [CW-1:0] LAST_BIT = CW'(Q - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        FIN,
        OUT
    } state_t;

    state_t state, state_d;

    // Sums in divider order: early_x, early_y, late_x, late_y
    logic signed [SUM_BITS-1:0] sum_q [4];
    logic        [COUNT_BITS-1:0] e_cnt, l_cnt;
    logic signed [D_BITS-1:0] cen [4];

    logic                  low_q;
    logic [1:0]            qsel;
    logic [CW-1:0]         bit_cnt;
    logic [Q-1:0]          num;
    logic [COUNT_BITS-1:0] rem;
    logic [Q-2:0]          quo;

    logic                         low_cond;
    logic                         bit_last;
    logic signed [SUM_BITS-1:0]   cur_sum;
    logic        [COUNT_BITS-1:0] cur_cnt;
    logic        [COUNT_BITS:0]   rem_sh;
    logic        [COUNT_BITS:0]   diff;
    logic                         fits;
    logic        [COUNT_BITS-1:0] rem_nx;
    logic        [Q-1:0]          quo_nx;
    logic        [D_BITS-1:0]     q_ext;
    logic signed [D_BITS-1:0]     cen_val;
    logic signed [D_BITS-1:0]     dx_c, dy_c;
    logic        [D_BITS-1:0]     ax_c, ay_c;

    // Magnitude of a signed sum scaled by the fraction bits; -2^(N-1) maps
    // cleanly onto an N-bit unsigned magnitude.
    function automatic logic [Q-1:0] mag_num(
        input logic [SUM_BITS-1:0] s
    );
        logic [SUM_BITS-1:0] m;
        m = s[SUM_BITS-1] ? (~s + 1'b1) : s;
        return {m, {FRAC_BITS{1'b0}}};
    endfunction

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == OUT);

    assign low_cond = (e_cnt < MIN_C) || (l_cnt < MIN_C);
    assign bit_last = (bit_cnt == LAST_BIT);
    assign cur_sum  = sum_q[qsel];
    assign cur_cnt  = qsel[1] ? l_cnt : e_cnt;

    // Restoring step: the remainder is always below the divisor, so the
    // borrow bit of the trial subtraction is the quotient-bit decision.
    always_comb begin
        rem_sh  = {rem, num[Q-1]};
        diff    = rem_sh - {1'b0, cur_cnt};
        fits    = ~diff[COUNT_BITS];
        rem_nx  = fits ? diff[COUNT_BITS-1:0] : rem_sh[COUNT_BITS-1:0];
        quo_nx  = {quo, fits};
        q_ext   = {1'b0, quo_nx};
        cen_val = cur_sum[SUM_BITS-1] ? -q_ext : q_ext;
    end

    always_comb begin
        dx_c = cen[2] - cen[0];
        dy_c = cen[3] - cen[1];
        ax_c = dx_c[D_BITS-1] ? -dx_c : dx_c;
        ay_c = dy_c[D_BITS-1] ? -dy_c : dy_c;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = CHECK;
            CHECK:   state_d = low_cond ? FIN : DIV;
            DIV:     if (bit_last && qsel == 2'd3) state_d = FIN;
            FIN:     state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sum_q[i] <= '0;
                cen[i]   <= '0;
            end
            e_cnt        <= '0;
            l_cnt        <= '0;
            low_q        <= 1'b0;
            qsel         <= '0;
            bit_cnt      <= '0;
            num          <= '0;
            rem          <= '0;
            quo          <= '0;
            delta_x      <= '0;
            delta_y      <= '0;
            abs_delta_x  <= '0;
            abs_delta_y  <= '0;
            total_events <= '0;
            low_activity <= 1'b0;
            dominant_x   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q[0] <= early_sum_x;
                        sum_q[1] <= early_sum_y;
                        sum_q[2] <= late_sum_x;
                        sum_q[3] <= late_sum_y;
                        e_cnt    <= early_count;
                        l_cnt    <= late_count;
                    end
                end
                CHECK: begin
                    low_q   <= low_cond;
                    qsel    <= '0;
                    bit_cnt <= '0;
                    num     <= mag_num(sum_q[0]);
                    rem     <= '0;
                    quo     <= '0;
                end
                DIV: begin
                    if (bit_last) begin
                        cen[qsel] <= cen_val;
                        qsel      <= qsel + 2'd1;
                        bit_cnt   <= '0;
                        num       <= mag_num(sum_q[qsel + 2'd1]);
                        rem       <= '0;
                        quo       <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        num     <= num << 1;
                        rem     <= rem_nx;
                        quo     <= quo_nx[Q-2:0];
                    end
                end
                FIN: begin
                    total_events <= {1'b0, e_cnt} + {1'b0, l_cnt};
                    low_activity <= low_q;
                    if (low_q) begin
                        delta_x     <= '0;
                        delta_y     <= '0;
                        abs_delta_x <= '0;
                        abs_delta_y <= '0;
                        dominant_x  <= 1'b1;
                    end else begin
                        delta_x     <= dx_c;
                        delta_y     <= dy_c;
                        abs_delta_x <= ax_c;
                        abs_delta_y <= ay_c;
                        dominant_x  <= (ax_c >= ay_c);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalized_motion_computer.sv
// Bench for normalized_motion_computer: vector table through a scoreboard
// queue, plus backpressure and mid-division reset sequences.
module tb_normalized_motion_computer;

    localparam int SB = 18;
    localparam int CB = 12;
    localparam int DB = 23;
    localparam int NV = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [SB-1:0] early_sum_x, early_sum_y;
    logic        [CB-1:0] early_count;
    logic signed [SB-1:0] late_sum_x, late_sum_y;
    logic        [CB-1:0] late_count;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DB-1:0] delta_x, delta_y;
    logic        [DB-1:0] abs_delta_x, abs_delta_y;
    logic        [CB:0]   total_events;
    logic                 low_activity;
    logic                 dominant_x;

    normalized_motion_computer #(
        .SUM_BITS  (SB),
        .COUNT_BITS(CB),
        .FRAC_BITS (4),
        .MIN_COUNT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .early_sum_x (early_sum_x),
        .early_sum_y (early_sum_y),
        .early_count (early_count),
        .late_sum_x  (late_sum_x),
        .late_sum_y  (late_sum_y),
        .late_count  (late_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .delta_x     (delta_x),
        .delta_y     (delta_y),
        .abs_delta_x (abs_delta_x),
        .abs_delta_y (abs_delta_y),
        .total_events(total_events),
        .low_activity(low_activity),
        .dominant_x  (dominant_x)
    );

    typedef struct {
        logic signed [SB-1:0] esx;
        logic signed [SB-1:0] esy;
        logic        [CB-1:0] ec;
        logic signed [SB-1:0] lsx;
        logic signed [SB-1:0] lsy;
        logic        [CB-1:0] lc;
        logic signed [DB-1:0] dx;
        logic signed [DB-1:0] dy;
        logic        [DB-1:0] ax;
        logic        [DB-1:0] ay;
        logic        [CB:0]   tot;
        logic                 low;
        logic                 dom;
        int                   lat;
    } vec_t;

    vec_t vecs [NV];
    vec_t sb_q [$];
    vec_t last;
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        early_sum_x = v.esx;
        early_sum_y = v.esy;
        early_count = v.ec;
        late_sum_x  = v.lsx;
        late_sum_y  = v.lsy;
        late_count  = v.lc;
        in_valid    = 1'b1;
    endtask

    task automatic send(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        chk({tag, ".in_ready"}, longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb_q.push_back(v);
    endtask

    task automatic wait_out(input string tag);
        int   cyc;
        vec_t e;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 200);
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            last = e;
            chk({tag, ".latency"}, cyc, e.lat);
            chk({tag, ".dx"}, longint'(delta_x), longint'(e.dx));
            chk({tag, ".dy"}, longint'(delta_y), longint'(e.dy));
            chk({tag, ".ax"}, longint'(abs_delta_x), longint'(e.ax));
            chk({tag, ".ay"}, longint'(abs_delta_y), longint'(e.ay));
            chk({tag, ".tot"}, longint'(total_events), longint'(e.tot));
            chk({tag, ".low"}, longint'(low_activity), longint'(e.low));
            chk({tag, ".dom"}, longint'(dominant_x), longint'(e.dom));
            chk({tag, ".busy"}, longint'(in_ready), 0);
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, longint'(out_valid), 0);
        chk({tag, ".ready_back"}, longint'(in_ready), 1);
        chk({tag, ".dx_held"}, longint'(delta_x), longint'(last.dx));
    endtask

    initial begin
        vec_t a, b;
        logic ok;

        vecs[0] = '{1000, 500, 10, 3000, 1000, 20, 800, 0, 800, 0, 30, 0, 1, 90};
        vecs[1] = '{-5, 0, 9, 0, 0, 9, 8, 0, 8, 0, 18, 0, 1, 90};
        vecs[2] = '{100, 100, 3, 200, 200, 50, 0, 0, 0, 0, 53, 1, 1, 2};
        vecs[3] = '{4095, 0, 4095, -4095, 0, 4095, -32, 0, 32, 0, 8190, 0, 1, 90};
        vecs[4] = '{-131072, 100, 8, 131071, -100, 8,
                    524286, -400, 524286, 400, 16, 0, 1, 90};
        vecs[5] = '{0, 0, 16, 16, -160, 16, 16, -160, 16, 160, 32, 0, 0, 90};
        vecs[6] = '{0, 0, 10, 10, -10, 10, 16, -16, 16, 16, 20, 0, 1, 90};
        vecs[7] = '{50, 50, 8, 50, 50, 7, 0, 0, 0, 0, 15, 1, 1, 2};
        vecs[8] = '{0, -1, 9, 0, 1, 9, 0, 2, 0, 2, 18, 0, 0, 90};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        early_sum_x = '0;
        early_sum_y = '0;
        early_count = '0;
        late_sum_x  = '0;
        late_sum_y  = '0;
        late_count  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", longint'(out_valid), 0);
        chk("rst.dx", longint'(delta_x), 0);
        chk("rst.tot", longint'(total_events), 0);
        chk("rst.dom", longint'(dominant_x), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", longint'(in_ready), 1);

        for (int i = 0; i < NV; i++) begin
            send($sformatf("v%0d", i), vecs[i]);
            wait_out($sformatf("v%0d", i));
            handshake($sformatf("v%0d", i));
        end

        // Backpressure: result A held while B is offered
        a = vecs[0];
        b = vecs[5];
        send("bp_a", a);
        wait_out("bp_a");
        @(negedge clk);
        drive(b);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            ok = out_valid && !in_ready && delta_x == a.dx &&
                 delta_y == a.dy && total_events == a.tot &&
                 dominant_x == a.dom && low_activity == a.low;
            chk($sformatf("bp_hold%0d", c), longint'(ok), 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.ov_drop", longint'(out_valid), 0);
        chk("bp.ready_back", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb_q.push_back(b);
        wait_out("bp_b");
        handshake("bp_b");

        // Reset in the middle of the divider
        send("rst_mid", vecs[4]);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", longint'(out_valid), 0);
        chk("rst_mid.dx", longint'(delta_x), 0);
        chk("rst_mid.ax", longint'(abs_delta_x), 0);
        chk("rst_mid.tot", longint'(total_events), 0);
        chk("rst_mid.low", longint'(low_activity), 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid.in_ready", longint'(in_ready), 1);
        send("post_rst", vecs[0]);
        wait_out("post_rst");
        handshake("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/normalized_motion_computer.md
Name: normalized_motion_computer

Overview:
- Successor motion-vector stage between the temporal accumulator and the gesture classifier.
- Computes true centroid differences: sum/count per window, in fixed point with FRAC_BITS fraction bits, using one shared sequential restoring divider.
- Gates low-activity windows and flags the dominant axis.
- Uses a valid/ready handshake on both sides; one transaction is in flight at a time.

Parameters:
SUM_BITS, 18, width of signed window sums
COUNT_BITS, 12, width of unsigned window counts
FRAC_BITS, 4, fraction bits of the centroid results
MIN_COUNT, 8, minimum per-window count for a valid motion estimate; must be >= 1
Derived, not overridable: Q = SUM_BITS+FRAC_BITS (divider cycles per quotient); D_BITS = Q+1 (delta width)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input window pair valid
in_ready  out  1  block can accept a window pair
early_sum_x  in  SUM_BITS  signed Σx, early window
early_sum_y  in  SUM_BITS  signed Σy, early window
early_count  in  COUNT_BITS  early event count
late_sum_x  in  SUM_BITS  signed Σx, late window
late_sum_y  in  SUM_BITS  signed Σy, late window
late_count  in  COUNT_BITS  late event count
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
delta_x  out  D_BITS  signed late_cx − early_cx, Q.FRAC_BITS format
delta_y  out  D_BITS  signed late_cy − early_cy
abs_delta_x  out  D_BITS  unsigned |delta_x|
abs_delta_y  out  D_BITS  unsigned |delta_y|
total_events  out  COUNT_BITS+1  early_count+late_count, no wrap
low_activity  out  1  either count < MIN_COUNT; deltas forced to 0
dominant_x  out  1  abs_delta_x >= abs_delta_y

Behaviour:
- Reset: single clock clk, reset rst_n asynchronous active-low.
  - State goes to IDLE.
  - All outputs become 0 except in_ready, which is 1 after release.
  - Reset mid-transaction discards it with no output.
- in_ready = (state == IDLE). Accept = in_valid && in_ready at a rising edge; all six inputs are latched on that edge.
- FSM states: IDLE, CHECK, DIV, FIN, OUT.
  - IDLE→CHECK on accept.
  - CHECK:
    - If early_count < MIN_COUNT or late_count < MIN_COUNT, go to FIN with low_activity=1.
    - Otherwise go to DIV with quotient index k=0.
  - DIV: restoring division, one quotient bit per cycle, Q cycles per quotient.
    - Order: early_x, early_y, late_x, late_y; 4·Q cycles total.
    - Numerator = |sum| << FRAC_BITS (Q-bit unsigned); divisor = count.
    - Quotient is truncated, then negated if sum < 0, giving round toward zero.
    - sum = −2^(SUM_BITS−1) must be handled; its magnitude fits in SUM_BITS unsigned.
  - FIN, one cycle, registers:
    - delta = late − early, sign-extended to D_BITS;
    - abs values;
    - total_events;
    - dominant_x;
    - low_activity.
    - On the low-activity path, delta and abs are 0 and dominant_x = 1.
  - OUT: out_valid=1, all outputs held stable; on out_ready go to IDLE and drop out_valid on the same edge.
- Latency from accept edge to out_valid high: 4·Q+2 cycles (90 at defaults); low-activity path: 2 cycles.
- Backpressure: while OUT and out_ready=0, outputs are frozen and in_valid is ignored.
- After the OUT→IDLE edge, in_ready=1 and the next accept can occur one cycle later.
- total_events is computed in COUNT_BITS+1 bits; it never wraps.
- Outputs keep their last values after the OUT handshake until the next FIN, except out_valid.

Test Plan:
- Nominal motion, defaults: early (sx=1000, sy=500, n=10), late (sx=3000, sy=1000, n=20) → delta_x=800 (50.0 px), delta_y=0, abs 800/0, total_events=30, dominant_x=1, low_activity=0; out_valid exactly 90 cycles after accept.
- Truncation toward zero: early sx=−5, n=9; late sx=0, n=9 → early_cx=−8 (from −80/9), delta_x=+8, abs_delta_x=8.
- Low activity: early_count=3, late_count=50 → low_activity=1, deltas/abs=0, dominant_x=1, total_events=53, out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new data → outputs stable, in_ready=0, nothing accepted; after out_ready pulse, next pair accepted and its result is correct.
- Reset mid-DIV: assert rst_n=0 at cycle 40 after accept → out_valid=0 and outputs 0 immediately; after release in_ready=1, next transaction yields correct result.
- Extremes: counts 4095/4095 → total_events=8190; early sx=−131072, n=8 → early_cx=−262144, no overflow; delta_x sign-correct.
